// File: rtl/async_fifo_prog.sv
// rtl/async_fifo_prog.sv - dual-clock Gray-pointer FIFO with programmable almost-full/almost-empty thresholds
// Sub-modules: a Gray pointer synchroniser and the write-side and read-side pointer/flag blocks.

module async_fifo_prog_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

module async_fifo_prog_wptr #(
    parameter int ADDRSIZE = 3
) (
    input  logic                wclk,
    input  logic                w_rstn,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rgray_sync,
    input  logic [ADDRSIZE:0]   af_thresh,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wen,
    output logic [ADDRSIZE:0]   wgray,
    output logic                wfull,
    output logic                almost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                woverflow
);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbin_next;
    logic [ADDRSIZE:0] wgray_next;
    logic [ADDRSIZE:0] rbin_sync;
    logic [ADDRSIZE:0] full_gray;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign wen        = winc && !wfull;
    assign wbin_next  = wbin + {{ADDRSIZE{1'b0}}, wen};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    assign rbin_sync  = gray2bin(rgray_sync);
    assign waddr      = wbin[ADDRSIZE-1:0];

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_gray = rgray_sync ^ {2'b11, {(ADDRSIZE-1){1'b0}}};

    always_ff @(posedge wclk or negedge w_rstn) begin
        if (!w_rstn) begin
            wbin      <= '0;
            wgray     <= '0;
            wfull     <= 1'b0;
            wcount    <= '0;
            woverflow <= 1'b0;
        end else begin
            wbin   <= wbin_next;
            wgray  <= wgray_next;
            wfull  <= (wgray_next == full_gray);
            wcount <= wbin_next - rbin_sync;
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end
        end
    end

    assign almost_full = (wcount >= af_thresh);

endmodule

module async_fifo_prog_rptr #(
    parameter int ADDRSIZE = 3
) (
    input  logic                rclk,
    input  logic                r_rstn,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wgray_sync,
    input  logic [ADDRSIZE:0]   ae_thresh,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                ren,
    output logic [ADDRSIZE:0]   rgray,
    output logic                rempty,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                runderflow
);

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbin_next;
    logic [ADDRSIZE:0] rgray_next;
    logic [ADDRSIZE:0] wbin_sync;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign ren        = rinc && !rempty;
    assign rbin_next  = rbin + {{ADDRSIZE{1'b0}}, ren};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    assign wbin_sync  = gray2bin(wgray_sync);
    assign raddr      = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk or negedge r_rstn) begin
        if (!r_rstn) begin
            rbin       <= '0;
            rgray      <= '0;
            rempty     <= 1'b1;
            rcount     <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin   <= rbin_next;
            rgray  <= rgray_next;
            rempty <= (rgray_next == wgray_sync);
            rcount <= wbin_sync - rbin_next;
            if (rinc && rempty) begin
                runderflow <= 1'b1;
            end
        end
    end

    assign almost_empty = (rcount <= ae_thresh);

endmodule

module async_fifo_prog #(
    parameter int DATESIZE    = 8,
    parameter int ADDRSIZE    = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FWFT        = 0
) (
    input  logic                wclk,
    input  logic                w_rstn,
    input  logic                rclk,
    input  logic                r_rstn,
    input  logic [DATESIZE-1:0] wdata,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   af_thresh,
    output logic                wfull,
    output logic                almost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                woverflow,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   ae_thresh,
    output logic [DATESIZE-1:0] rdata,
    output logic                rempty,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                runderflow
);

    localparam int DEPTH = 1 << ADDRSIZE;

    logic [DATESIZE-1:0] mem [DEPTH];
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE-1:0] raddr;
    logic                wen;
    logic                ren;
    logic [ADDRSIZE:0]   wgray;
    logic [ADDRSIZE:0]   rgray;
    logic [ADDRSIZE:0]   wgray_sync;
    logic [ADDRSIZE:0]   rgray_sync;

    async_fifo_prog_sync #(.WIDTH(ADDRSIZE + 1), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk  (wclk),
        .rstn (w_rstn),
        .d    (rgray),
        .q    (rgray_sync)
    );

    async_fifo_prog_sync #(.WIDTH(ADDRSIZE + 1), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk  (rclk),
        .rstn (r_rstn),
        .d    (wgray),
        .q    (wgray_sync)
    );

    async_fifo_prog_wptr #(.ADDRSIZE(ADDRSIZE)) u_wptr (
        .wclk        (wclk),
        .w_rstn      (w_rstn),
        .winc        (winc),
        .rgray_sync  (rgray_sync),
        .af_thresh   (af_thresh),
        .waddr       (waddr),
        .wen         (wen),
        .wgray       (wgray),
        .wfull       (wfull),
        .almost_full (almost_full),
        .wcount      (wcount),
        .woverflow   (woverflow)
    );

    async_fifo_prog_rptr #(.ADDRSIZE(ADDRSIZE)) u_rptr (
        .rclk         (rclk),
        .r_rstn       (r_rstn),
        .rinc         (rinc),
        .wgray_sync   (wgray_sync),
        .ae_thresh    (ae_thresh),
        .raddr        (raddr),
        .ren          (ren),
        .rgray        (rgray),
        .rempty       (rempty),
        .almost_empty (almost_empty),
        .rcount       (rcount),
        .runderflow   (runderflow)
    );

    always_ff @(posedge wclk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // The slot at raddr is stable while the read side sees it as non-empty, so the
    // cross-domain array read is safe in both modes.
    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = rempty ? '0 : mem[raddr];
        end else begin : g_reg
            always_ff @(posedge rclk or negedge r_rstn) begin
                if (!r_rstn) begin
                    rdata <= '0;
                end else if (ren) begin
                    rdata <= mem[raddr];
                end
            end
        end
    endgenerate

endmodule
